// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - handshake bundle between decode, immediate generator and operand mux
//
// Groups the instruction-in and result-out handshakes of imm_gen_pipe.
//   in_valid  / in_ready  / in_instr               : instruction offered by the producer
//   out_valid / out_ready / out_instr / out_imme
//   / out_type                                     : result presented to the consumer
// Modports:
//   slave  - the immediate generator (accepts instructions, drives results)
//   master - the environment around it (offers instructions, consumes results)

interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [XLEN-1:0] out_imme;
    logic [2:0]      out_type;

    modport slave (
        input  in_valid,
        input  in_instr,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_instr,
        output out_imme,
        output out_type
    );

    modport master (
        output in_valid,
        output in_instr,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_instr,
        input  out_imme,
        input  out_type
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered immediate generator with two-entry skid buffer and flush
//
// Accepts one 32-bit instruction per cycle, classifies its immediate format,
// and presents the instruction together with its XLEN-wide extended
// immediate one cycle later. An output register plus one skid register keep
// full throughput while in_ready is driven from registered state only.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   rst    - synchronous active-high reset (priority over flush)
//   flush  - drop every held entry and any instruction offered this cycle
//   bus    - imm_gen_pipe_if.slave: in_valid/in_ready/in_instr,
//            out_valid/out_ready/out_instr/out_imme/out_type
//
// Format codes on out_type: 0 none, 1 I, 2 U, 3 J, 4 B, 5 S, 6 Z (CSR uimm).
//
// Optional feature macro: IMMGEN_CSR_EN
//   defined   - csrrwi/csrrsi/csrrci (SYSTEM with instr[14]=1) yield type 6
//               with instr[19:15] zero-extended.
//   undefined - every SYSTEM encoding yields type 0, immediate 0.

module imm_gen_pipe #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    imm_gen_pipe_if.slave bus
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] TYPE_NONE = 3'd0;
    localparam logic [2:0] TYPE_I    = 3'd1;
    localparam logic [2:0] TYPE_U    = 3'd2;
    localparam logic [2:0] TYPE_J    = 3'd3;
    localparam logic [2:0] TYPE_B    = 3'd4;
    localparam logic [2:0] TYPE_S    = 3'd5;
`ifdef IMMGEN_CSR_EN
    localparam logic [2:0] TYPE_Z    = 3'd6;
`endif

    localparam bit IS_RV64 = (XLEN == 64);

    // ------------------------------------------------------------------
    // Decode of the instruction currently offered on the input.
    // ------------------------------------------------------------------
    logic [31:0]     in_instr;
    logic [6:0]      opcode;
    logic [2:0]      dec_type;
    logic [31:0]     dec_imm32;
    logic [XLEN-1:0] dec_imme;

    assign in_instr = bus.in_instr;
    assign opcode   = in_instr[6:0];

    // Every format fits in 32 bits with its sign at bit 31 (the CSR uimm is
    // non-negative), so a single signed widening to XLEN covers both the
    // sign-extended formats and the zero-extended CSR immediate.
    always_comb begin
        dec_type  = TYPE_NONE;
        dec_imm32 = '0;
        case (opcode)
            OP_JALR, OP_LOAD, OP_IMM: begin
                dec_type  = TYPE_I;
                dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OP_IMM32: begin
                // op-imm-32 only exists on RV64; on RV32 it is an unknown opcode.
                if (IS_RV64) begin
                    dec_type  = TYPE_I;
                    dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                end
            end
            OP_LUI, OP_AUIPC: begin
                dec_type  = TYPE_U;
                dec_imm32 = {in_instr[31:12], 12'b0};
            end
            OP_JAL: begin
                dec_type  = TYPE_J;
                dec_imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                             in_instr[30:21], 1'b0};
            end
            OP_BRANCH: begin
                dec_type  = TYPE_B;
                dec_imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                             in_instr[11:8], 1'b0};
            end
            OP_STORE: begin
                dec_type  = TYPE_S;
                dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
`ifdef IMMGEN_CSR_EN
            OP_SYSTEM: begin
                // Only the immediate CSR forms carry a uimm; ecall/ebreak/mret
                // and the register CSR forms stay type 0.
                if (in_instr[14]) begin
                    dec_type  = TYPE_Z;
                    dec_imm32 = {27'b0, in_instr[19:15]};
                end
            end
`else
            OP_SYSTEM: begin
                dec_type  = TYPE_NONE;
                dec_imm32 = '0;
            end
`endif
            default: begin
                dec_type  = TYPE_NONE;
                dec_imm32 = '0;
            end
        endcase
    end

    assign dec_imme = XLEN'($signed(dec_imm32));

    // ------------------------------------------------------------------
    // Storage: main output register and one skid register.
    // ------------------------------------------------------------------
    logic            out_valid_q,  out_valid_d;
    logic [31:0]     out_instr_q,  out_instr_d;
    logic [XLEN-1:0] out_imme_q,   out_imme_d;
    logic [2:0]      out_type_q,   out_type_d;

    logic            skid_valid_q, skid_valid_d;
    logic [31:0]     skid_instr_q, skid_instr_d;
    logic [XLEN-1:0] skid_imme_q,  skid_imme_d;
    logic [2:0]      skid_type_q,  skid_type_d;

    logic in_ready;
    logic accept;
    logic pop;

    // in_ready comes from the skid flag only, so there is no combinational
    // path from out_ready back to the producer.
    assign in_ready = !skid_valid_q && !rst;
    assign accept   = bus.in_valid && in_ready;
    assign pop      = out_valid_q && bus.out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_imme_d   = out_imme_q;
        out_type_d   = out_type_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_imme_d  = skid_imme_q;
        skid_type_d  = skid_type_q;

        if (flush) begin
            // Flush beats accept and pop; held data are left in place but
            // are no longer valid.
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (pop && skid_valid_q) begin
            // Skid entry is older than anything new; accept is impossible
            // here because in_ready is low while the skid is full.
            out_valid_d  = 1'b1;
            out_instr_d  = skid_instr_q;
            out_imme_d   = skid_imme_q;
            out_type_d   = skid_type_q;
            skid_valid_d = 1'b0;
        end else if (accept && (!out_valid_q || pop)) begin
            // Output register empty or draining: new entry goes straight out.
            out_valid_d  = 1'b1;
            out_instr_d  = in_instr;
            out_imme_d   = dec_imme;
            out_type_d   = dec_type;
        end else if (accept) begin
            // Output register held by a stalled consumer: park in the skid.
            skid_valid_d = 1'b1;
            skid_instr_d = in_instr;
            skid_imme_d  = dec_imme;
            skid_type_d  = dec_type;
        end else if (pop) begin
            out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_instr_q  <= '0;
            out_imme_q   <= '0;
            out_type_q   <= TYPE_NONE;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_imme_q  <= '0;
            skid_type_q  <= TYPE_NONE;
        end else begin
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_imme_q   <= out_imme_d;
            out_type_q   <= out_type_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_imme_q  <= skid_imme_d;
            skid_type_q  <= skid_type_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_imme  = out_imme_q;
    assign bus.out_type  = out_type_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe against a queue-based reference model

module tb_imm_gen_pipe;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    imm_gen_pipe_if #(.XLEN(XLEN)) bus ();

    imm_gen_pipe #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: instructions held by the stage, oldest first (capacity 2).
    logic [31:0] mq[$];
    bit          zero_expect = 1'b0;
    bit          chk_en      = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Two's-complement interpretation of a w-bit field, widened to 64 bits.
    function automatic logic [63:0] sext(input logic [63:0] v, input int w);
        logic [63:0] r;
        r = v;
        if (v[w-1]) r = v - (64'd1 << w);
        return r;
    endfunction

    function automatic void ref_decode(input logic [31:0] ins, output logic [2:0] t,
                                       output logic [63:0] imm);
        t   = 3'd0;
        imm = 64'd0;
        case (ins[6:0])
            7'h67, 7'h03, 7'h13: begin
                t = 3'd1; imm = sext(64'(ins[31:20]), 12);
            end
            7'h1B: begin
                if (XLEN == 64) begin
                    t = 3'd1; imm = sext(64'(ins[31:20]), 12);
                end
            end
            7'h37, 7'h17: begin
                t = 3'd2; imm = sext(64'({ins[31:12], 12'b0}), 32);
            end
            7'h6F: begin
                t = 3'd3;
                imm = sext(64'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}), 21);
            end
            7'h63: begin
                t = 3'd4;
                imm = sext(64'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}), 13);
            end
            7'h23: begin
                t = 3'd5; imm = sext(64'({ins[31:25], ins[11:7]}), 12);
            end
`ifdef IMMGEN_CSR_EN
            7'h73: begin
                if (ins[14]) begin
                    t = 3'd6; imm = 64'(ins[19:15]);
                end
            end
`endif
            default: ;
        endcase
    endfunction

    function automatic logic [63:0] trunc(input logic [63:0] v);
        return 64'(v[XLEN-1:0]);
    endfunction

    // One clock: advance the model with the inputs present at the edge.
    task automatic step();
        int  cnt;
        bit  do_pop;
        bit  do_acc;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            zero_expect = 1'b1;
        end else if (flush) begin
            mq.delete();
        end else begin
            cnt    = mq.size();
            do_pop = (cnt > 0) && bus.out_ready;
            do_acc = bus.in_valid && (cnt < 2);
            if (do_pop) void'(mq.pop_front());
            if (do_acc) begin
                mq.push_back(bus.in_instr);
                zero_expect = 1'b0;
            end
        end
        #1;
    endtask

    task automatic expect_out(input string name, input logic [31:0] ins,
                              input logic [2:0] t, input logic [63:0] imm);
        check({name, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({name, "_instr"}, 64'(bus.out_instr), 64'(ins));
        check({name, "_type"},  64'(bus.out_type),  64'(t));
        check({name, "_imme"},  64'(bus.out_imme),  trunc(imm));
    endtask

    // Per-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        logic [2:0]  et;
        logic [63:0] ei;
        if (chk_en) begin
            check("in_ready",  64'(bus.in_ready),  64'(!rst && (mq.size() < 2)));
            check("out_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
            if (mq.size() > 0) begin
                ref_decode(mq[0], et, ei);
                check("out_instr", 64'(bus.out_instr), 64'(mq[0]));
                check("out_type",  64'(bus.out_type),  64'(et));
                check("out_imme",  64'(bus.out_imme),  trunc(ei));
            end else if (zero_expect) begin
                check("rst_instr", 64'(bus.out_instr), 64'd0);
                check("rst_type",  64'(bus.out_type),  64'd0);
                check("rst_imme",  64'(bus.out_imme),  64'd0);
            end
        end
    end

    logic [31:0] sweep_ins [5] = '{32'h123450B7, 32'hFFDFF06F, 32'hFE000EE3,
                                   32'h00112623, 32'h00208033};
    logic [2:0]  sweep_t   [5] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    logic [63:0] sweep_imm [5] = '{64'h0000_0000_1234_5000, 64'hFFFF_FFFF_FFFF_FFFC,
                                   64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_0000_000C,
                                   64'h0};
    logic [6:0]  ops [12] = '{7'h67, 7'h03, 7'h13, 7'h1B, 7'h37, 7'h17,
                              7'h6F, 7'h63, 7'h23, 7'h73, 7'h33, 7'h0F};

    initial begin
        logic [2:0]  mt;
        logic [63:0] mi;
        logic [31:0] r;

        rst          = 1'b1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_instr = 32'h0;
        bus.out_ready = 1'b0;

        // Pin the model with hand-derived values.
        ref_decode(32'hFFF00093, mt, mi);
        check("model_addi_type", 64'(mt), 64'd1);
        check("model_addi_imm",  mi, 64'hFFFF_FFFF_FFFF_FFFF);
        ref_decode(32'hFE000EE3, mt, mi);
        check("model_beq_imm",   mi, 64'hFFFF_FFFF_FFFF_FFFC);
        ref_decode(32'h00112623, mt, mi);
        check("model_sw_imm",    mi, 64'h0000_0000_0000_000C);

        // Reset held two cycles.
        step();
        chk_en = 1'b1;
        step();
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_type",  64'(bus.out_type),  64'd0);
        check("rst_out_imme",  64'(bus.out_imme),  64'd0);
        check("rst_out_instr", 64'(bus.out_instr), 64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd0);

        // Basic I-type.
        rst = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'hFFF00093;
        bus.out_ready = 1'b1;
        #1;
        check("post_rst_ready", 64'(bus.in_ready), 64'd1);
        step();
        expect_out("addi", 32'hFFF00093, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF);

        // Format sweep, back to back.
        for (int i = 0; i < 5; i++) begin
            bus.in_instr = sweep_ins[i];
            step();
            expect_out($sformatf("sweep%0d", i), sweep_ins[i], sweep_t[i], sweep_imm[i]);
        end

        // Back-pressure: A, B accepted, C stalls.
        bus.in_valid = 1'b0;
        step();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h00A00113;   // A: addi x2,x0,10
        step();
        bus.in_instr  = 32'h000010B7;   // B: lui x1,1
        step();
        check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        bus.in_instr  = 32'h00812023;   // C: sw x8,0(x2)
        step();
        check("bp_hold_a", 64'(bus.out_instr), 64'h00A00113);
        bus.out_ready = 1'b1;
        step();
        check("bp_out_b", 64'(bus.out_instr), 64'h000010B7);
        step();
        check("bp_out_c", 64'(bus.out_instr), 64'h00812023);
        bus.in_valid = 1'b0;
        step();
        check("bp_drained", 64'(bus.out_valid), 64'd0);

        // Flush with both registers full while D is offered.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h00100093;
        step();
        bus.in_instr  = 32'h00200093;
        step();
        flush        = 1'b1;
        bus.in_instr = 32'hDEAD0037;    // D
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        check("flush_in_ready",  64'(bus.in_ready),  64'd1);
        bus.out_ready = 1'b1;
        step();
        check("flush_no_d", 64'(bus.out_valid), 64'd0);

        // CSR immediate.
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h300FD073;
        step();
`ifdef IMMGEN_CSR_EN
        expect_out("csr", 32'h300FD073, 3'd6, 64'h1F);
`else
        expect_out("csr", 32'h300FD073, 3'd0, 64'h0);
`endif

        // Mid-operation reset with both entries full.
        bus.out_ready = 1'b0;
        bus.in_instr  = 32'h00300093;
        step();
        bus.in_instr  = 32'h00400093;
        step();
        rst = 1'b1;
        step();
        check("mrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mrst_out_instr", 64'(bus.out_instr), 64'd0);
        check("mrst_out_type",  64'(bus.out_type),  64'd0);
        check("mrst_out_imme",  64'(bus.out_imme),  64'd0);
        check("mrst_in_ready",  64'(bus.in_ready),  64'd0);
        rst = 1'b0;
        bus.in_instr  = 32'h00500293;   // addi x5,x0,5
        bus.out_ready = 1'b1;
        #1;
        check("mrst_ready_back", 64'(bus.in_ready), 64'd1);
        step();
        expect_out("mrst_first", 32'h00500293, 3'd1, 64'd5);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            r = $urandom();
            rst           = ($urandom_range(0, 299) == 0);
            flush         = ($urandom_range(0, 39) == 0);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.in_instr  = {r[31:7], ops[$urandom_range(0, 11)]};
            step();
        end

        rst = 1'b0;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        step();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
